lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencing controller for the memory/writeback stage of the three-stage pipeline. Turns a load or store in that stage into one request/acknowledge transaction on the data bus and stalls the pipeline while it is in flight. Returns the aligned, sign-extended load word and pulses `loaded`, which the hazard unit uses to release a load-use stall.

## Interface
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width; fixed at 32 for RV32
- `TIMEOUT`, 255, ACCESS-state cycle limit before a bus error (only with the macro)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `mem_read` in 1: load in the MW stage
- `mem_write` in 1: store in the MW stage; never asserted together with `mem_read`
- `funct3` in 3: access size and sign (RV32 encoding)
- `addr` in `ADDR_W`: effective address from the ALU
- `wdata` in 32: store data, right-aligned
- `bus_req` out 1: transaction request, registered
- `bus_we` out 1: 1 for a store
- `bus_addr` out `ADDR_W`: word-aligned address (`addr[1:0]` forced to 0)
- `bus_be` out 4: byte enables
- `bus_wdata` out 32: store data shifted into lane position
- `bus_ack` in 1: slave completion, one-cycle pulse
- `bus_rdata` in 32: read data, valid with `bus_ack`
- `rdata` out 32: extracted load result
- `loaded` out 1: load result valid this cycle
- `stall` out 1: freezes PC and the IF/MW registers
- `bus_err` out 1: timeout pulse (only with the macro)

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - `stall = mem_read | mem_write`, combinational.
  - On either op: latch `bus_addr`, `bus_be`, `bus_wdata`, `bus_we`, `funct3` and `addr[1:0]`, then go to ACCESS.
- **ACCESS**
  - `bus_req = 1` and `stall = 1`; all bus outputs held stable.
  - On `bus_ack`: register the extracted load data into `rdata`, then go to DONE.
- **DONE**
  - `stall = 0`; `loaded = 1` for loads only.
  - Next state is IDLE unconditionally, so the same instruction is never re-issued.
- **Byte enables**
  - SB: `4'b0001 << addr[1:0]`
  - SH: `4'b0011 << {addr[1],1'b0}`
  - SW: `4'b1111`
- **Misaligned accesses:** not detected. Halfword uses `addr[1]` only; word ignores `addr[1:0]`.
- **Load extraction:**
  - LB/LBU: select byte `addr[1:0]`; LH/LHU: select halfword `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **`flush`:** not an input. An access already in ACCESS always completes; stores are never dropped.
- **`bus_ack` outside ACCESS:** ignored.

## Timing
- **Reset values:** state IDLE, `bus_req`/`bus_we`/`loaded`/`bus_err` 0, `bus_addr`/`bus_be`/`bus_wdata`/`rdata` 0.
- **Zero-wait slave:**
  - Cycle N: op seen in IDLE, `stall=1`.
  - Cycle N+1: ACCESS, `bus_req=1`, `bus_ack=1`.
  - Cycle N+2: DONE, `loaded=1`, `rdata` valid.
  - Result: minimum 2 stall cycles per access.
- **k wait cycles:** stall lasts 2+k cycles.
- **Back-to-back memory ops:** the second op is seen in IDLE at cycle N+3.
- **`rst` mid-ACCESS:** returns immediately to IDLE and drops `bus_req`. The slave must tolerate an abandoned request.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter clears on ACCESS entry and increments each ACCESS cycle without `bus_ack`.
  - At `TIMEOUT` the block drops `bus_req`, goes to DONE with `rdata=0` and `bus_err=1` for that DONE cycle; `loaded` still pulses for a load.
  - `bus_ack` in the same cycle as the limit wins: normal completion, no error.
- **Undefined:** no counter; ACCESS waits indefinitely; `bus_err` tied to 0.

## Structure
- **`lsu_pkg`:**
  - `lsu_state_e` enum
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - byte-enable width constant
- **Sub-module `lsu_align`:** purely combinational; byte-enable generation, store lane shift, load extraction and extension. `lsu_ctrl` holds the FSM, registers and counter.

## Test plan
- LW addr `0x100`, zero-wait ack, `bus_rdata=0xDEADBEEF` -> `stall` high 2 cycles, `bus_be=4'hF`, `bus_addr=0x100`, `rdata=0xDEADBEEF`, `loaded` pulse 1 cycle.
- LB addr `0x103`, rdata `0x80000000` -> `rdata=0xFFFFFF80`; same with LBU -> `0x00000080`.
- SH addr `0x202`, `wdata=0x1234`, 3 wait cycles -> `bus_be=4'b1100`, `bus_wdata=0x12340000`, `bus_we=1`, stall 5 cycles, `loaded` stays 0.
- Back-to-back LW then SW -> `bus_req` deasserts for exactly DONE+IDLE, second request in cycle N+4.
- `rst` asserted during ACCESS -> `bus_req=0` and state IDLE same cycle; later `bus_ack` ignored.
- With `LSU_TIMEOUT_EN`, `TIMEOUT=4`, no ack -> `bus_req` drops after 4 ACCESS cycles, `bus_err=1`, `rdata=0`, `loaded=1`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// States, RV32 load/store funct3 encodings and byte-enable width.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

endpackage

// File: rtl/lsu_align.sv
// Lane logic: byte enables, store lane shift, load extract/extend.
// Purely combinational; misalignment is deliberately not detected.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      i_st_f3,
  input  logic [1:0]      i_st_lo,
  input  logic [31:0]     i_wdata,
  input  logic [2:0]      i_ld_f3,
  input  logic [1:0]      i_ld_lo,
  input  logic [31:0]     i_raw,
  output logic [BE_W-1:0] o_be,
  output logic [31:0]     o_wdata,
  output logic [31:0]     o_rdata
);

  logic [1:0]  w_sz;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_sz = i_st_f3[1:0];

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    unique case (1'b1)
      (w_sz == F3_B[1:0]): begin
        o_be    = 4'b0001 << i_st_lo;
        o_wdata = {24'b0, i_wdata[7:0]} << {i_st_lo, 3'b000};
      end
      (w_sz == F3_H[1:0]): begin
        o_be    = 4'b0011 << {i_st_lo[1], 1'b0};
        o_wdata = {16'b0, i_wdata[15:0]} << {i_st_lo[1], 4'b0000};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_b = i_raw[{i_ld_lo, 3'b000} +: 8];
    w_h = i_ld_lo[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_rdata = i_raw;
    unique case (1'b1)
      (i_ld_f3 == F3_B):  o_rdata = {{24{w_b[7]}}, w_b};
      (i_ld_f3 == F3_BU): o_rdata = {24'b0, w_b};
      (i_ld_f3 == F3_H):  o_rdata = {{16{w_h[15]}}, w_h};
      (i_ld_f3 == F3_HU): o_rdata = {16'b0, w_h};
      default:            o_rdata = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MW-stage load/store sequencer: one req/ack bus transaction per op.
// Define LSU_TIMEOUT_EN to add the ACCESS timeout and bus_err pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              loaded,
  output logic              stall,
  output logic              bus_err
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_f3;
  logic [1:0]        r_lo;
  logic [DATA_W-1:0] r_rdata;

  logic              w_op;
  logic              w_tmo;
  logic              w_limit;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wsh;
  logic [DATA_W-1:0] w_ext;

  assign w_op = mem_read | mem_write;

  lsu_align u_align (
    .i_st_f3 (funct3),
    .i_st_lo (addr[1:0]),
    .i_wdata (wdata),
    .i_ld_f3 (r_f3),
    .i_ld_lo (r_lo),
    .i_raw   (bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wsh),
    .o_rdata (w_ext)
  );

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall = w_op;
        if (w_op) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (bus_ack) begin
          w_next = S_DONE;
        end else if (w_limit) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == S_ACCESS);
      if (r_state == S_IDLE && w_op) begin
        r_we    <= mem_write;
        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wsh;
        r_f3    <= funct3;
        r_lo    <= addr[1:0];
      end
      if (r_state == S_ACCESS && w_next == S_DONE) begin
        r_rdata <= w_tmo ? '0 : w_ext;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_limit = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (r_state != S_ACCESS) begin
        r_cnt <= '0;
      end else if (!bus_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus_err = r_err;
`else
  assign w_limit = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign loaded    = (r_state == S_DONE) & ~r_we;

endmodule
